sram22_req_ctrl: RTL

Valid/ready request front end for the sram22 single-port macros (default geometry 128x16, two 8-bit write lanes). Accepts read/write requests from a client, drives the macro's `ce`/`we`/`wmask`/`addr`/`din` pins directly, captures `dout` one cycle after each read, and returns read data through a small in-order response FIFO with backpressure. It also generates the macro's active-low `rstb` from the block reset.

---
 rtl/sram22_req_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram22_req_ctrl.sv
// Valid/ready request front end for an sram22 single-port macro: drives the macro pins directly,
// captures read data one cycle after each read and returns it through an in-order response FIFO.
module sram22_req_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned WMASK_WIDTH = 2,
  parameter int unsigned RESP_DEPTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_din,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,

  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_LIM  = OCC_W'(RESP_DEPTH);

  logic [1:0]            rst_sync;
  logic                  rd_pending;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [DATA_WIDTH-1:0] storage [RESP_DEPTH];
  logic [OCC_W-1:0]      occupancy;
  logic                  fire;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Macro reset: asserts with rst, releases on the second clock edge after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign sram_rstb = rst_sync[1];

  // Reserve a slot for every read still in flight so a capture can never find the FIFO full.
  assign occupancy = OCC_W'(count) + OCC_W'(rd_pending);
  assign req_ready = sram_rstb & (occupancy < OCC_LIM);
  assign fire      = req_valid & req_ready;

  assign sram_ce    = fire;
  assign sram_we    = req_we;
  assign sram_wmask = req_wmask;
  assign sram_addr  = req_addr;
  assign sram_din   = req_din;

  assign push      = rd_pending;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = storage[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= fire & ~req_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The macro holds dout until the next read, so the capture is unaffected by a write this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) begin
        storage[i] <= '0;
      end
    end else if (push) begin
      storage[tail] <= sram_dout;
    end
  end

endmodule
